entropy_decoder: RTL and testbench
==================================

# entropy_decoder

Bit-serial baseline-JPEG Huffman entropy decoder for one 8x8 block stream. It takes the packed entropy-coded bitstream (Huffman symbols plus appended amplitude bits) one bit per cycle and decodes DC and AC symbols with the Annex K luminance tables. It adds the DC predictor, expands zero runs, ZRL and EOB, and emits all 64 coefficients in zigzag order. Its output is the `(index, coeff)` stream the entropy encoder consumes, so the two blocks sit back-to-back in loopback tests and in the decode path.

## Interface
Parameters: none (tables fixed in package).
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  `in_bit` valid this cycle
- `in_bit`  in  1  next stream bit, MSB-first per JPEG
- `in_ready`  out  1  decoder accepts a bit this cycle (`in_valid && in_ready` = bit consumed)
- `out_valid`  out  1  coefficient valid, one-cycle pulse per coefficient
- `out_index`  out  6  zigzag index 0..63
- `out_coeff`  out  16  signed coefficient
- `out_block_done`  out  1  high with `out_index`==63
- `err`  out  1  sticky decode error

## Operation
- States: `DC_HUFF`, `DC_AMP`, `AC_HUFF`, `ZERO_RUN`, `AC_AMP`, `FILL`, `ERROR`.
- **Huffman decode (DC_HUFF/AC_HUFF):** canonical MINCODE/MAXCODE/VALPTR method.
  - Per accepted bit: `code=(code<<1)|bit`, `len++`.
  - If `code<=MAXCODE[len]`, then `sym=HUFFVAL[VALPTR[len]+code-MINCODE[len]]`.
  - `len` reaching 16 without a match -> `ERROR`.
- **DC:** `sym` = size s; s>11 -> `ERROR`.
  - s=0: diff=0, emit immediately.
  - Otherwise `DC_AMP` reads s bits into v.
  - `diff = v[s-1] ? v : v-(2^s-1)`.
  - `coeff = pred+diff`, wrapping mod 2^16; `pred` updated; emit at index 0; go to `AC_HUFF`.
- **AC symbols** {r,s}:
  - 0x00 EOB: `FILL` emits zeros up to index 63.
  - 0xF0 ZRL: `ZERO_RUN` with 16 zeros.
  - Other: `ZERO_RUN` emits r zeros, then `AC_AMP` reads s bits (s 1..10), sign-extends as for DC, and emits.
  - s=0 with r not in {0,15} -> `ERROR`.
  - Any emission that would pass index 63 -> `ERROR`; the offending coefficient is not emitted.
- **Block end:** emitting index 63 by any path sets `out_block_done`, resets the index counter, and returns to `DC_HUFF`. No EOB is expected after a coefficient at index 63.
- **`pred`:** cleared only by `rst_n`; persists across blocks.
- **`ERROR`:** absorbing; `err`=1, `in_ready`=0, no outputs until reset.

## Timing
- **Reset values:** `in_ready`=0 during reset, 1 in the first cycle after; `out_valid`=0, `out_index`=0, `out_coeff`=0, `out_block_done`=0, `err`=0, `pred`=0; state `DC_HUFF`.
- **Outputs:** all registered.
  - The coefficient ending on a bit appears with `out_valid` the cycle after that bit is consumed.
  - `in_valid` gaps stall decode without losing state.
- **`in_ready`:** 1 only in `DC_HUFF`, `DC_AMP`, `AC_HUFF`, `AC_AMP`; 0 in `ZERO_RUN`, `FILL`, `ERROR`.
- **Zero emission:** `ZERO_RUN`/`FILL` emit one zero per cycle with contiguous `out_valid`. A ZRL costs 16 cycles and a run r costs r cycles before amplitude bits are accepted.
- **No output backpressure:** the consumer must sink one coefficient per cycle.
- **Reset mid-block:** immediate abort; the next bit starts a new DC decode with `pred`=0.

## Structure
- **Package `jpeg_huff_pkg`:**
  - DC/AC luminance BITS and HUFFVAL, plus derived MINCODE/MAXCODE/VALPTR constant arrays.
  - State enum.
  - `amp_extend(v,s)` function.
  - Constants `EOB`=8'h00, `ZRL`=8'hF0.
- **Sub-module `huff_sym_lookup`:** combinational; (table_sel, code, len) -> (match, sym). Instantiated once and shared by DC and AC.

## Test plan
- **Zero block:** bits `00` `1010` -> index 0 coeff 0, then indices 1..63 coeff 0 on 63 consecutive cycles; `out_block_done` at 63.
- **DC predictor and AC sign:**
  - Block 1: `011` `10`, then `00` `0`, then `1010` -> index 0 = +2, index 1 = -1, rest 0.
  - Block 2: `010` `1` `1010` -> index 0 = +3.
- **ZRL:** `00`, `11111111001` x3, `00` `1`, `1010` -> indices 1..48 zero, index 49 = +1, rest 0; `in_ready` low during each 16-cycle run.
- **Run overflow and invalid code:**
  - Overflow: `00` + ZRL x4 -> 48 zeros emitted, then `err`=1 after the 4th ZRL's last bit; no further `out_valid`.
  - Invalid code: sixteen `1`s -> `err` after the 16th bit.
- **Stalls and reset:**
  - Stalls: the test-2 stream with random `in_valid` gaps -> identical coefficient sequence.
  - Reset mid-block: assert `rst_n`=0 mid-block, then `010` `1` `1010` -> index 0 = +1 (`pred` cleared).

Source files
------------

// File: rtl/jpeg_huff_pkg.sv
// Shared constants for the baseline-JPEG luminance Huffman decoder:
// Annex K DC/AC tables, canonical decode tables, FSM states, amplitude helper.
package jpeg_huff_pkg;

    typedef enum logic [2:0] {
        DC_HUFF  = 3'd0,
        DC_AMP   = 3'd1,
        AC_HUFF  = 3'd2,
        ZERO_RUN = 3'd3,
        AC_AMP   = 3'd4,
        FILL     = 3'd5,
        ERROR    = 3'd6
    } dec_state_e;

    localparam logic [7:0] EOB = 8'h00;
    localparam logic [7:0] ZRL = 8'hF0;

    // All per-length arrays are indexed by (code length - 1).
    // Entries for lengths with no codes are unused (BITS is zero there).
    localparam logic [7:0] DC_BITS [0:15] = '{
        8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
        8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0
    };
    localparam logic [15:0] DC_MINCODE [0:15] = '{
        16'd0, 16'd0, 16'd2, 16'd14, 16'd30, 16'd62, 16'd126, 16'd254,
        16'd510, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
    };
    localparam logic [15:0] DC_MAXCODE [0:15] = '{
        16'd0, 16'd0, 16'd6, 16'd14, 16'd30, 16'd62, 16'd126, 16'd254,
        16'd510, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
    };
    localparam logic [7:0] DC_VALPTR [0:15] = '{
        8'd0, 8'd0, 8'd1, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10,
        8'd11, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0
    };
    // Padded to 16 so a 4-bit index never leaves the array.
    localparam logic [7:0] DC_HUFFVAL [0:15] = '{
        8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
        8'd8, 8'd9, 8'd10, 8'd11, 8'd0, 8'd0, 8'd0, 8'd0
    };

    localparam logic [7:0] AC_BITS [0:15] = '{
        8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3,
        8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'd125
    };
    localparam logic [15:0] AC_MINCODE [0:15] = '{
        16'd0, 16'd0, 16'd4, 16'd10, 16'd26, 16'd58, 16'd120, 16'd248,
        16'd502, 16'd1014, 16'd2038, 16'd4084, 16'd0, 16'd0, 16'd32704, 16'd65410
    };
    localparam logic [15:0] AC_MAXCODE [0:15] = '{
        16'd0, 16'd1, 16'd4, 16'd12, 16'd28, 16'd59, 16'd123, 16'd250,
        16'd506, 16'd1018, 16'd2041, 16'd4087, 16'd0, 16'd0, 16'd32704, 16'd65534
    };
    localparam logic [7:0] AC_VALPTR [0:15] = '{
        8'd0, 8'd0, 8'd2, 8'd3, 8'd6, 8'd9, 8'd11, 8'd15,
        8'd18, 8'd23, 8'd28, 8'd32, 8'd0, 8'd0, 8'd36, 8'd37
    };
    localparam logic [7:0] AC_HUFFVAL [0:161] = '{
        8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
        8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
        8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08,
        8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
        8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16,
        8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
        8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
        8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
        8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59,
        8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
        8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79,
        8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
        8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98,
        8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
        8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6,
        8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
        8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4,
        8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
        8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea,
        8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
        8'hf9, 8'hfa
    };

    // JPEG EXTEND: an s-bit amplitude with MSB 0 encodes a negative value.
    function automatic logic [15:0] amp_extend(input logic [10:0] v, input logic [3:0] s);
        logic [15:0] vv;
        logic [15:0] lim;
        logic [3:0]  msb;
        vv  = {5'd0, v};
        lim = (16'd1 << s) - 16'd1;
        msb = s - 4'd1;
        if (s == 4'd0) begin
            return 16'd0;
        end else if (vv[msb]) begin
            return vv;
        end else begin
            return vv - lim;
        end
    endfunction

endpackage

// File: rtl/huff_sym_lookup.sv
// Canonical Huffman symbol lookup for a partially assembled code word.
// Shared by DC and AC decode; table_sel=1 selects the AC table.
module huff_sym_lookup
    import jpeg_huff_pkg::*;
(
    input  logic        table_sel,
    input  logic [15:0] code,
    input  logic [4:0]  len,
    output logic        match,
    output logic [7:0]  sym
);

    logic [3:0]  li;
    logic [7:0]  nbits;
    logic [7:0]  vptr;
    logic [15:0] minc;
    logic [15:0] maxc;
    logic [7:0]  off;
    logic [7:0]  hidx;

    // Select table row for this length, test MAXCODE, index HUFFVAL.
    always_comb begin
        li = len[3:0] - 4'd1;
        if (table_sel) begin
            nbits = AC_BITS[li];
            vptr  = AC_VALPTR[li];
            minc  = AC_MINCODE[li];
            maxc  = AC_MAXCODE[li];
        end else begin
            nbits = DC_BITS[li];
            vptr  = DC_VALPTR[li];
            minc  = DC_MINCODE[li];
            maxc  = DC_MAXCODE[li];
        end
        // Offset within one length class is always below 256.
        off   = code[7:0] - minc[7:0];
        hidx  = vptr + off;
        match = (len != 5'd0) && (nbits != 8'd0) && (code <= maxc);
        sym   = table_sel ? AC_HUFFVAL[hidx] : DC_HUFFVAL[hidx[3:0]];
    end

endmodule

// File: rtl/entropy_decoder.sv
// Bit-serial baseline-JPEG luminance entropy decoder for 8x8 blocks.
// Handshake: a bit is consumed on a rising edge where in_valid && in_ready;
// there is no output backpressure, out_valid is a one-cycle pulse per coefficient.
module entropy_decoder
    import jpeg_huff_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    output logic [5:0]  out_index,
    output logic [15:0] out_coeff,
    output logic        out_block_done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    dec_state_e  state_q, state_d;
    logic [15:0] code_q, code_d;
    logic [4:0]  len_q, len_d;
    logic [10:0] amp_v_q, amp_v_d;
    logic [3:0]  amp_s_q, amp_s_d;
    logic [3:0]  amp_cnt_q, amp_cnt_d;
    logic [4:0]  run_q, run_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] pred_q, pred_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [5:0]  out_index_q, out_index_d;
    logic [15:0] out_coeff_q, out_coeff_d;
    logic        out_done_q, out_done_d;
    logic        err_q, err_d;

    logic        accept;
    logic [15:0] code_shift;
    logic [4:0]  len_inc;
    logic [10:0] amp_shift;
    logic [3:0]  cnt_inc;
    logic [15:0] amp_val;
    logic        lk_match;
    logic [7:0]  lk_sym;
    logic [3:0]  sym_r;
    logic [3:0]  sym_s;

    assign accept     = in_valid && in_ready_q;
    assign code_shift = {code_q[14:0], in_bit};
    assign len_inc    = len_q + 5'd1;
    assign amp_shift  = {amp_v_q[9:0], in_bit};
    assign cnt_inc    = amp_cnt_q + 4'd1;
    assign amp_val    = amp_extend(amp_shift, amp_s_q);
    assign sym_r      = lk_sym[7:4];
    assign sym_s      = lk_sym[3:0];

    huff_sym_lookup u_lookup (
        .table_sel (state_q == AC_HUFF),
        .code      (code_shift),
        .len       (len_inc),
        .match     (lk_match),
        .sym       (lk_sym)
    );

    // Next-state, coefficient emission and predictor update.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        len_d       = len_q;
        amp_v_d     = amp_v_q;
        amp_s_d     = amp_s_q;
        amp_cnt_d   = amp_cnt_q;
        run_d       = run_q;
        idx_d       = idx_q;
        pred_d      = pred_q;
        out_valid_d = 1'b0;
        out_index_d = out_index_q;
        out_coeff_d = out_coeff_q;
        out_done_d  = 1'b0;
        case (state_q)
            DC_HUFF: begin
                if (accept) begin
                    if (lk_match) begin
                        code_d = 16'd0;
                        len_d  = 5'd0;
                        if (lk_sym > 8'd11) begin
                            state_d = ERROR;
                        end else if (sym_s == 4'd0) begin
                            out_valid_d = 1'b1;
                            out_index_d = 6'd0;
                            out_coeff_d = pred_q;
                            idx_d       = 6'd1;
                            state_d     = AC_HUFF;
                        end else begin
                            amp_s_d   = sym_s;
                            amp_cnt_d = 4'd0;
                            amp_v_d   = 11'd0;
                            state_d   = DC_AMP;
                        end
                    end else if (len_inc == 5'd16) begin
                        state_d = ERROR;
                    end else begin
                        code_d = code_shift;
                        len_d  = len_inc;
                    end
                end
            end
            DC_AMP: begin
                if (accept) begin
                    amp_v_d   = amp_shift;
                    amp_cnt_d = cnt_inc;
                    if (cnt_inc == amp_s_q) begin
                        pred_d      = pred_q + amp_val;
                        out_valid_d = 1'b1;
                        out_index_d = 6'd0;
                        out_coeff_d = pred_q + amp_val;
                        idx_d       = 6'd1;
                        state_d     = AC_HUFF;
                    end
                end
            end
            AC_HUFF: begin
                if (accept) begin
                    if (lk_match) begin
                        code_d = 16'd0;
                        len_d  = 5'd0;
                        if (lk_sym == EOB) begin
                            state_d = FILL;
                        end else if (lk_sym == ZRL) begin
                            // Reject up front if the 16 zeros would run past index 63.
                            if (({1'b0, idx_q} + 7'd16) > 7'd64) begin
                                state_d = ERROR;
                            end else begin
                                run_d   = 5'd16;
                                amp_s_d = 4'd0;
                                state_d = ZERO_RUN;
                            end
                        end else if ((sym_s == 4'd0) || (sym_s > 4'd10)) begin
                            state_d = ERROR;
                        end else if (({1'b0, idx_q} + {3'b000, sym_r}) > 7'd63) begin
                            state_d = ERROR;
                        end else begin
                            amp_s_d   = sym_s;
                            amp_cnt_d = 4'd0;
                            amp_v_d   = 11'd0;
                            run_d     = {1'b0, sym_r};
                            state_d   = (sym_r == 4'd0) ? AC_AMP : ZERO_RUN;
                        end
                    end else if (len_inc == 5'd16) begin
                        state_d = ERROR;
                    end else begin
                        code_d = code_shift;
                        len_d  = len_inc;
                    end
                end
            end
            ZERO_RUN: begin
                out_valid_d = 1'b1;
                out_index_d = idx_q;
                out_coeff_d = 16'd0;
                run_d       = run_q - 5'd1;
                if (run_q == 5'd1) begin
                    // amp_s == 0 marks a ZRL; otherwise an amplitude follows.
                    if (amp_s_q != 4'd0) begin
                        idx_d   = idx_q + 6'd1;
                        state_d = AC_AMP;
                    end else if (idx_q == 6'd63) begin
                        out_done_d = 1'b1;
                        idx_d      = 6'd0;
                        state_d    = DC_HUFF;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = AC_HUFF;
                    end
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            AC_AMP: begin
                if (accept) begin
                    amp_v_d   = amp_shift;
                    amp_cnt_d = cnt_inc;
                    if (cnt_inc == amp_s_q) begin
                        out_valid_d = 1'b1;
                        out_index_d = idx_q;
                        out_coeff_d = amp_val;
                        if (idx_q == 6'd63) begin
                            out_done_d = 1'b1;
                            idx_d      = 6'd0;
                            state_d    = DC_HUFF;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            state_d = AC_HUFF;
                        end
                    end
                end
            end
            FILL: begin
                out_valid_d = 1'b1;
                out_index_d = idx_q;
                out_coeff_d = 16'd0;
                if (idx_q == 6'd63) begin
                    out_done_d = 1'b1;
                    idx_d      = 6'd0;
                    state_d    = DC_HUFF;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
        in_ready_d = (state_d == DC_HUFF) || (state_d == DC_AMP) ||
                     (state_d == AC_HUFF) || (state_d == AC_AMP);
        err_d      = (state_d == ERROR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DC_HUFF;
            code_q      <= 16'd0;
            len_q       <= 5'd0;
            amp_v_q     <= 11'd0;
            amp_s_q     <= 4'd0;
            amp_cnt_q   <= 4'd0;
            run_q       <= 5'd0;
            idx_q       <= 6'd0;
            pred_q      <= 16'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= 6'd0;
            out_coeff_q <= 16'd0;
            out_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            len_q       <= len_d;
            amp_v_q     <= amp_v_d;
            amp_s_q     <= amp_s_d;
            amp_cnt_q   <= amp_cnt_d;
            run_q       <= run_d;
            idx_q       <= idx_d;
            pred_q      <= pred_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_coeff_q <= out_coeff_d;
            out_done_q  <= out_done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_index      = out_index_q;
    assign out_coeff      = out_coeff_q;
    assign out_block_done = out_done_q;
    assign err            = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_entropy_decoder.sv
// Directed bench for entropy_decoder: hand-coded bitstreams, expected
// coefficient queue, cycle/ready checks and error-path checks.
module tb_entropy_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        out_valid;
    logic [5:0]  out_index;
    logic [15:0] out_coeff;
    logic        out_block_done;
    logic        err;
    logic [2:0]  dbg_state;

    entropy_decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_bit         (in_bit),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_index      (out_index),
        .out_coeff      (out_coeff),
        .out_block_done (out_block_done),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int low_cnt  = 0;
    bit low_en   = 1'b0;
    bit gaps_en  = 1'b0;

    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    int          got_cyc[$];

    always @(posedge clk) cyc = cyc + 1;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back({out_block_done, out_index, out_coeff});
            got_cyc.push_back(cyc);
        end
        if (low_en && !in_ready) low_cnt = low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- driver ----------------
    task automatic send_bit(input logic b);
        int guard = 0;
        bit done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                done = 1'b1;
            end else if (gaps_en && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
            end else if (!in_ready) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_bit   = b;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1'b1;
            end
        end
    endtask

    task automatic send_bits(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h30) send_bit(1'b0);
            else if (s[i] == 8'h31) send_bit(1'b1);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Expected block: c0 at index 0, nz_val at nz_idx (if nonzero index), zeros elsewhere.
    task automatic exp_block(input logic [15:0] c0, input int nz_idx,
                             input logic [15:0] nz_val, input int last);
        logic [15:0] c;
        logic [5:0]  ix;
        for (int i = 0; i <= last; i++) begin
            ix = i[5:0];
            c  = (i == 0) ? c0 : ((i == nz_idx) ? nz_val : 16'd0);
            exp_q.push_back({(i == 63), ix, c});
        end
    endtask

    task automatic wait_and_compare(input string tag);
        int guard = 0;
        while ((got_q.size() < exp_q.size()) && (guard < 600)) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; (i < exp_q.size()) && (i < got_q.size()); i++)
            check($sformatf("%s_c%0d", tag, i), {9'd0, got_q[i]}, {9'd0, exp_q[i]});
    endtask

    task automatic clear_sb();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_coeff", out_coeff, 0);
        check("rst_block_done", out_block_done, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Zero block: DC size 0, then EOB.
        exp_block(16'd0, 0, 16'd0, 63);
        send_bits("00 1010");
        wait_and_compare("zero_blk");
        if (got_cyc.size() == 64)
            check("zero_fill_contig", got_cyc[63] - got_cyc[1], 62);
        else
            check("zero_fill_size", got_cyc.size(), 64);
        clear_sb();

        // Predictor and AC sign: block1 DC +2, AC -1; block2 diff +1 -> +3.
        exp_block(16'd2, 1, 16'hFFFF, 63);
        exp_block(16'd3, 0, 16'd0, 63);
        send_bits("011 10 00 0 1010");
        send_bits("010 1 1010");
        wait_and_compare("pred_sign");
        clear_sb();

        // ZRL x3, then +1 at index 49; pred is 3 so index 0 = 3.
        low_cnt = 0;
        low_en  = 1'b1;
        exp_block(16'd3, 49, 16'd1, 63);
        send_bits("00 11111111001 11111111001 11111111001 00 1 1010");
        wait_and_compare("zrl");
        low_en = 1'b0;
        check("zrl_ready_low_cycles", low_cnt, 62);
        if (got_cyc.size() == 64)
            check("zrl_run_contig", got_cyc[16] - got_cyc[1], 15);
        else
            check("zrl_size", got_cyc.size(), 64);
        clear_sb();

        // Run overflow: 4th ZRL would pass index 63.
        exp_block(16'd3, 0, 16'd0, 48);
        send_bits("00 11111111001 11111111001 11111111001");
        check("ovf_err_before", err, 0);
        send_bits("11111111001");
        @(negedge clk);
        check("ovf_err", err, 1);
        check("ovf_in_ready", in_ready, 0);
        repeat (40) @(negedge clk);
        wait_and_compare("ovf");
        check("ovf_err_sticky", err, 1);
        do_reset();
        check("ovf_err_cleared", err, 0);

        // Invalid code: sixteen 1s.
        send_bits("111111111111111");
        repeat (3) @(negedge clk);
        check("inv_err_before", err, 0);
        send_bits("1");
        @(negedge clk);
        check("inv_err", err, 1);
        check("inv_in_ready", in_ready, 0);
        check("inv_no_out", got_q.size(), 0);
        do_reset();

        // Stalls: same stream as predictor test with random in_valid gaps.
        gaps_en = 1'b1;
        exp_block(16'd2, 1, 16'hFFFF, 63);
        exp_block(16'd3, 0, 16'd0, 63);
        send_bits("011 10 00 0 1010");
        send_bits("010 1 1010");
        wait_and_compare("stall");
        gaps_en = 1'b0;
        clear_sb();

        // Reset mid-block clears pred: next block DC diff +1 -> +1.
        send_bits("011 10 00 0");
        repeat (2) @(negedge clk);
        do_reset();
        exp_block(16'd1, 0, 16'd0, 63);
        send_bits("010 1 1010");
        wait_and_compare("mid_rst");
        clear_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
